// File: rtl/ex2_sweep_pkg.sv
// ex2_sweep_pkg: shared state encoding, default sizing and vector-count helper for the sweep checker
package ex2_sweep_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  localparam int W_DEF = 2;
  localparam int SETTLE_DEF = 1;
  function automatic int unsigned num_vecs(input int unsigned w);
    return 32'd1 << (2 * w);
  endfunction
endpackage

// File: rtl/ex2_sweep_ctrl_if.sv
// ex2_sweep_ctrl_if: control, result and DUT/reference operand bus of the sweep checker
interface ex2_sweep_ctrl_if import ex2_sweep_pkg::*; #(parameter int W = W_DEF);
  logic start;
  logic [W-1:0] a_o, b_o, y_dut, y_ref;
  logic busy, done, pass, fail_valid;
  logic [2*W:0] err_cnt;
  logic [2*W-1:0] fail_vec;
  modport master (input start, y_dut, y_ref,
                  output a_o, b_o, busy, done, pass, err_cnt, fail_valid, fail_vec);
  modport slave (output start, y_dut, y_ref,
                 input a_o, b_o, busy, done, pass, err_cnt, fail_valid, fail_vec);
endinterface

// File: rtl/sweep_vec_gen.sv
// sweep_vec_gen: ascending {a,b} vector counter with clear, increment and last-vector flag
module sweep_vec_gen import ex2_sweep_pkg::*; #(parameter int W = W_DEF) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic [2*W-1:0] vec,
  output logic last
);
  logic [2*W:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : inc ? cnt + 1'b1 : cnt;
  assign vec = cnt[2*W-1:0];
  assign last = cnt == (2*W+1)'(num_vecs(W) - 1);
endmodule

// File: rtl/ex2_sweep_ctrl.sv
// ex2_sweep_ctrl: exhaustive {a,b} sweep comparing a DUT against a reference copy.
// Define SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module ex2_sweep_ctrl import ex2_sweep_pkg::*; #(
  parameter int W = W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input logic clk,
  input logic rst_n,
  ex2_sweep_ctrl_if.master m
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam state_t NXT = SETTLE == 0 ? CHECK : WAIT;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] vec;
  logic last, miss, stop, clr, inc;
  assign miss = m.y_dut != m.y_ref;
`ifdef SWEEP_STOP_ON_FAIL_EN
  assign stop = miss;
`else
  assign stop = 1'b0;
`endif
  assign clr = state == IDLE && m.start;
  assign inc = state == CHECK && !last && !stop;
  sweep_vec_gen #(.W(W)) u_vec (.clk, .rst_n, .clr, .inc, .vec, .last);
  assign {m.a_o, m.b_o} = vec;
  // The settle window is WAIT plus the CHECK cycle, so WAIT lasts SETTLE cycles.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      m.busy <= 1'b0;
      m.done <= 1'b0;
      m.pass <= 1'b0;
      m.err_cnt <= '0;
      m.fail_valid <= 1'b0;
      m.fail_vec <= '0;
    end else begin
      m.done <= 1'b0;
      case (state)
        IDLE: if (m.start) begin
          state <= NXT;
          cnt <= CW'(SETTLE - 1);
          m.busy <= 1'b1;
          m.pass <= 1'b0;
          m.err_cnt <= '0;
          m.fail_valid <= 1'b0;
          m.fail_vec <= '0;
        end
        WAIT: if (cnt == '0) state <= CHECK; else cnt <= cnt - 1'b1;
        CHECK: begin
          if (miss) begin
            m.err_cnt <= m.err_cnt + 1'b1;
            if (!m.fail_valid) begin
              m.fail_valid <= 1'b1;
              m.fail_vec <= vec;
            end
          end
          if (last || stop) begin
            state <= DONE;
            m.busy <= 1'b0;
            m.done <= 1'b1;
            m.pass <= !miss && m.err_cnt == '0;
          end else begin
            state <= NXT;
            cnt <= CW'(SETTLE - 1);
          end
        end
        DONE: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ex2_sweep_ctrl.sv
// tb_ex2_sweep_ctrl: directed table-driven bench for the sweep checker (SETTLE 1, 0 and 3 instances)
module tb_ex2_sweep_ctrl;
  import ex2_sweep_pkg::*;
  typedef struct {
    int mode;
    bit poke;
    int lat;
    int err;
    bit fv;
    logic [3:0] fvec;
    bit pass;
    logic [3:0] endvec;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic aux_start = 1'b0;
  int mode = 0;
  int checks = 0;
  int errors = 0;
  vec_t tbl[4];
  always #5 clk = ~clk;
  ex2_sweep_ctrl_if #(.W(2)) m1 ();
  ex2_sweep_ctrl_if #(.W(2)) m0 ();
  ex2_sweep_ctrl_if #(.W(2)) m3 ();
  ex2_sweep_ctrl #(.W(2), .SETTLE(1)) u1 (.clk(clk), .rst_n(rst_n), .m(m1.master));
  ex2_sweep_ctrl #(.W(2), .SETTLE(0)) u0 (.clk(clk), .rst_n(rst_n), .m(m0.master));
  ex2_sweep_ctrl #(.W(2), .SETTLE(3)) u3 (.clk(clk), .rst_n(rst_n), .m(m3.master));
  assign m1.y_ref = m1.a_o ^ m1.b_o;
  assign m1.y_dut = mode == 2 ? ~m1.y_ref :
                    m1.y_ref ^ ((mode == 1 && m1.a_o == 2'd1 && m1.b_o == 2'd2) ? 2'b01 : 2'b00);
  assign m0.y_ref = m0.a_o & m0.b_o;
  assign m0.y_dut = m0.y_ref;
  assign m3.y_ref = m3.a_o | m3.b_o;
  assign m3.y_dut = m3.y_ref;
  assign m0.start = aux_start;
  assign m3.start = aux_start;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ab"}, {m1.a_o, m1.b_o}, 0);
    chk({tag, "_busy"}, m1.busy, 0);
    chk({tag, "_done"}, m1.done, 0);
    chk({tag, "_pass"}, m1.pass, 0);
    chk({tag, "_err_cnt"}, m1.err_cnt, 0);
    chk({tag, "_fail_valid"}, m1.fail_valid, 0);
    chk({tag, "_fail_vec"}, m1.fail_vec, 0);
  endtask

  task automatic sweep(input vec_t v);
    int n;
    mode = v.mode;
    @(negedge clk);
    m1.start = 1'b1;
    @(posedge clk);
    #1;
    m1.start = 1'b0;
    chk("busy_at_start", m1.busy, 1);
    chk("vec0_at_start", {m1.a_o, m1.b_o}, 0);
    n = 0;
    while (!m1.done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      m1.start = v.poke && {m1.a_o, m1.b_o} == 4'd7 && !m1.done;
    end
    m1.start = 1'b0;
    chk("done_latency", n, v.lat);
    chk("busy_at_done", m1.busy, 0);
    chk("pass", m1.pass, v.pass);
    chk("err_cnt", m1.err_cnt, v.err);
    chk("fail_valid", m1.fail_valid, v.fv);
    chk("fail_vec", m1.fail_vec, v.fvec);
    chk("end_vec", {m1.a_o, m1.b_o}, v.endvec);
    @(posedge clk);
    #1;
    chk("done_one_cycle", m1.done, 0);
    chk("err_cnt_hold", m1.err_cnt, v.err);
    chk("pass_hold", m1.pass, v.pass);
    chk("end_vec_hold", {m1.a_o, m1.b_o}, v.endvec);
  endtask

  initial begin
    int n, d0, d3;
    m1.start = 1'b0;
    tbl[0] = '{mode: 0, poke: 0, lat: 32, err: 0, fv: 0, fvec: 4'h0, pass: 1, endvec: 4'hF};
`ifdef SWEEP_STOP_ON_FAIL_EN
    tbl[1] = '{mode: 1, poke: 0, lat: 14, err: 1, fv: 1, fvec: 4'h6, pass: 0, endvec: 4'h6};
    tbl[2] = '{mode: 2, poke: 0, lat: 2, err: 1, fv: 1, fvec: 4'h0, pass: 0, endvec: 4'h0};
`else
    tbl[1] = '{mode: 1, poke: 0, lat: 32, err: 1, fv: 1, fvec: 4'h6, pass: 0, endvec: 4'hF};
    tbl[2] = '{mode: 2, poke: 0, lat: 32, err: 16, fv: 1, fvec: 4'h0, pass: 0, endvec: 4'hF};
`endif
    tbl[3] = '{mode: 0, poke: 1, lat: 32, err: 0, fv: 0, fvec: 4'h0, pass: 1, endvec: 4'hF};
    #1;
    chk_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // SETTLE=0 and SETTLE=3 instances started on the same edge
    @(negedge clk);
    aux_start = 1'b1;
    @(posedge clk);
    #1;
    aux_start = 1'b0;
    d0 = -1;
    d3 = -1;
    for (int j = 0; j <= 70; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (j < 16) chk("s0_step", {m0.a_o, m0.b_o}, j);
      if (j < 64) chk("s3_step", {m3.a_o, m3.b_o}, j / 4);
      if (m0.done && d0 < 0) d0 = j;
      if (m3.done && d3 < 0) d3 = j;
    end
    chk("s0_done_at", d0, 16);
    chk("s3_done_at", d3, 64);
    chk("s0_pass", m0.pass, 1);
    chk("s3_pass", m3.pass, 1);
    for (int i = 0; i < 4; i++) sweep(tbl[i]);
    // asynchronous abort partway through a sweep, then a clean rerun
    mode = 0;
    @(negedge clk);
    m1.start = 1'b1;
    @(posedge clk);
    #1;
    m1.start = 1'b0;
    n = 0;
    while ({m1.a_o, m1.b_o} != 4'd9 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reached_vec9", {m1.a_o, m1.b_o}, 9);
    chk("busy_at_vec9", m1.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    sweep(tbl[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
